// File: rtl/rand_pkg.sv
// Shared types and the bound-to-mask helper for the bounded random buffer.
package rand_pkg;

  typedef logic [31:0] rword_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } rbb_state_t;

  // Smallest 2^k-1 covering b-1: smear the top set bit of b-1 downward.
  function automatic rword_t mask_for_bound(input rword_t b);
    rword_t m;
    if (b == 32'd0) begin
      m = 32'hFFFF_FFFF;
    end else if (b == 32'd1) begin
      m = 32'd0;
    end else begin
      m = b - 32'd1;
      m = m | (m >> 1);
      m = m | (m >> 2);
      m = m | (m >> 4);
      m = m | (m >> 8);
      m = m | (m >> 16);
    end
    return m;
  endfunction

endpackage

// File: rtl/rand_bound_mask.sv
// Combinational bound -> sampling mask; the top registers the result during FLUSH.
module rand_bound_mask
  import rand_pkg::*;
(
  input  logic [31:0] bound_i,
  output logic [31:0] mask_o
);

  assign mask_o = mask_for_bound(bound_i);

endmodule

// File: rtl/rand_bounded_buf.sv
// Mask-and-reject sampler turning raw random words into values in [0, BOUND),
// buffered in a small FIFO behind a valid/ready port.
module rand_bounded_buf
  import rand_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [31:0]      RNG_DATA,
  output logic             RNG_ADV,
  input  logic [31:0]      BOUND,
  input  logic             BOUND_LD,
  output logic [31:0]      OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [CNT_W-1:0] REJ_CNT
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] REJ_ONE   = CNT_W'(1);

  rbb_state_t       state_q;
  rword_t           bound_q;
  rword_t           mask_q;
  rword_t           mask_d;
  rword_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [CNT_W-1:0] rej_q;

  rword_t cand;
  logic   accept;
  logic   pop;
  logic   push;
  logic   rej_inc;

  rand_bound_mask u_mask (
    .bound_i (bound_q),
    .mask_o  (mask_d)
  );

  assign OUT_VALID = (state_q == RUN) && (count_q != '0);
  assign OUT_DATA  = OUT_VALID ? mem_q[rd_ptr_q] : '0;
  assign REJ_CNT   = rej_q;

  assign pop     = OUT_VALID && OUT_READY;
  // No word is consumed while held in reset or while the mask is being rebuilt.
  assign RNG_ADV = !RESET && (state_q == RUN) && ((count_q < FIFO_FULL) || pop);
  assign cand    = RNG_DATA & mask_q;
  assign accept  = (bound_q == '0) || (cand < bound_q);
  assign push    = RNG_ADV && accept;
  assign rej_inc = RNG_ADV && !accept;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= RUN;
      bound_q  <= '0;
      mask_q   <= 32'hFFFF_FFFF;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rej_q    <= '0;
    end else if (BOUND_LD) begin
      state_q  <= FLUSH;
      bound_q  <= BOUND;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rej_q    <= '0;
    end else begin
      case (state_q)
        FLUSH: begin
          mask_q  <= mask_d;
          state_q <= RUN;
        end
        default: begin
          if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
          if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
          if (push && !pop)      count_q <= count_q + CNT_ONE;
          else if (pop && !push) count_q <= count_q - CNT_ONE;
          if (rej_inc && (rej_q != '1)) rej_q <= rej_q + REJ_ONE;
        end
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge CLK) begin
    if (!RESET && !BOUND_LD && push) mem_q[wr_ptr_q] <= cand;
  end

endmodule
